alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_if.sv | 35 +++
 rtl/alu_arbiter.sv | 132 +++++++++++++
 tb/tb_alu_arbiter.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// Handshake bundle between two ALU requesters, the arbiter and the response consumer.
interface alu_arbiter_if;
    logic       r0_valid;
    logic       r0_ready;
    logic [3:0] r0_op;
    logic [7:0] r0_a;
    logic [7:0] r0_b;
    logic       r1_valid;
    logic       r1_ready;
    logic [3:0] r1_op;
    logic [7:0] r1_a;
    logic [7:0] r1_b;
    logic       resp_valid;
    logic       resp_ready;
    logic [7:0] resp_data;
    logic       resp_id;
    logic       resp_err;
    logic       busy;

    modport slave (
        input  r0_valid, r0_op, r0_a, r0_b,
        input  r1_valid, r1_op, r1_a, r1_b,
        input  resp_ready,
        output r0_ready, r1_ready,
        output resp_valid, resp_data, resp_id, resp_err, busy
    );

    modport master (
        output r0_valid, r0_op, r0_a, r0_b,
        output r1_valid, r1_op, r1_a, r1_b,
        output resp_ready,
        input  r0_ready, r1_ready,
        input  resp_valid, resp_data, resp_id, resp_err, busy
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of a shared 8-bit ALU (IDLE/EXEC/RESP).
// Optional macro ALU_ARB_DIVZERO_CHK_EN: divide/modulo by zero returns 0xFF with err set.
module alu_arbiter #(
    parameter int RESET_PRIO = 0
) (
    input  logic         clk,
    input  logic         rst,
    alu_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic PRIO_INIT = (RESET_PRIO != 0);

    state_t     state;
    logic       prio;
    logic       grant0;
    logic       grant1;
    logic [3:0] op_p0;
    logic [7:0] a_p0;
    logic [7:0] b_p0;
    logic       id_p0;
    logic       resp_valid_q;
    logic [7:0] resp_data_q;
    logic       resp_id_q;
    logic       resp_err_q;
    logic       busy_q;

    // Returns {err, data}; everything wraps modulo 256.
    function automatic logic [8:0] alu(input logic [3:0] op, input logic [7:0] a,
                                       input logic [7:0] b);
        logic [15:0] prod;
        logic [7:0]  res;
        logic        err;
        prod = 16'(a) * 16'(b);
        res  = 8'h00;
        err  = 1'b0;
        case (op)
            4'b0000: res = a + b;
            4'b0001: res = a - b;
            4'b0010: res = prod[7:0];
`ifdef ALU_ARB_DIVZERO_CHK_EN
            4'b0011: if (b == 8'h00) begin res = 8'hFF; err = 1'b1; end else res = a / b;
            4'b1100: if (b == 8'h00) begin res = 8'hFF; err = 1'b1; end else res = a % b;
`else
            4'b0011: res = a / b;
            4'b1100: res = a % b;
`endif
            4'b0100: res = a & b;
            4'b0110: res = a | b;
            4'b0111: res = a ^ b;
            4'b1000: res = (b >= 8'd8) ? 8'h00 : (a << b[2:0]);
            4'b1001,
            4'b1010: res = (b >= 8'd8) ? 8'h00 : (a >> b[2:0]);
            default: begin res = 8'h00; err = 1'b1; end
        endcase
        return {err, res};
    endfunction

    // Grant is combinational so a requester sees ready in the same cycle it asserts valid.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!rst && state == IDLE) begin
            if (bus.r0_valid && (!bus.r1_valid || prio == 1'b0))
                grant0 = 1'b1;
            else if (bus.r1_valid)
                grant1 = 1'b1;
        end
    end

    // Stage p0: operand capture on accept
    always_ff @(posedge clk) begin
        if (grant0) begin
            op_p0 <= bus.r0_op;
            a_p0  <= bus.r0_a;
            b_p0  <= bus.r0_b;
        end else if (grant1) begin
            op_p0 <= bus.r1_op;
            a_p0  <= bus.r1_a;
            b_p0  <= bus.r1_b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            prio         <= PRIO_INIT;
            id_p0        <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= 8'h00;
            resp_id_q    <= 1'b0;
            resp_err_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant0 || grant1) begin
                        state  <= EXEC;
                        busy_q <= 1'b1;
                        id_p0  <= grant1;
                        prio   <= grant0;
                    end
                end
                EXEC: begin
                    {resp_err_q, resp_data_q} <= alu(op_p0, a_p0, b_p0);
                    resp_id_q    <= id_p0;
                    resp_valid_q <= 1'b1;
                    state        <= RESP;
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        resp_valid_q <= 1'b0;
                        busy_q       <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.r0_ready   = grant0;
    assign bus.r1_ready   = grant1;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_id    = resp_id_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed cases plus randomized transactions
// against a transaction-level reference of arbitration and ALU arithmetic.
module tb_alu_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;
    int   prio_m = 0;

    alu_arbiter_if bus();

    alu_arbiter #(.RESET_PRIO(0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // d = -1 means the result is unspecified and must not be checked.
    task automatic ref_alu(input int op, input int a, input int b, output int d, output int e);
        d = 0;
        e = 0;
        case (op)
            0:  d = (a + b) % 256;
            1:  d = (a - b + 256) % 256;
            2:  d = (a * b) % 256;
            3, 12: begin
                if (b == 0) begin
`ifdef ALU_ARB_DIVZERO_CHK_EN
                    d = 255;
                    e = 1;
`else
                    d = -1;
`endif
                end else begin
                    d = (op == 3) ? a / b : a % b;
                end
            end
            4:  d = a & b;
            6:  d = a | b;
            7:  d = a ^ b;
            8:  d = (b >= 8) ? 0 : (a * (1 << b)) % 256;
            9, 10: d = (b >= 8) ? 0 : a / (1 << b);
            default: begin d = 0; e = 1; end
        endcase
    endtask

    task automatic run_txn(input bit v0, input bit v1,
                           input logic [3:0] op0, input logic [7:0] a0, input logic [7:0] b0,
                           input logic [3:0] op1, input logic [7:0] a1, input logic [7:0] b1,
                           input int stall, input string tag);
        int g;
        int ed;
        int ee;
        bus.r0_valid = v0; bus.r0_op = op0; bus.r0_a = a0; bus.r0_b = b0;
        bus.r1_valid = v1; bus.r1_op = op1; bus.r1_a = a1; bus.r1_b = b1;
        bus.resp_ready = 1'b0;
        #1;
        g = (v0 && v1) ? prio_m : (v0 ? 0 : 1);
        chk({tag, ".r0_ready"}, bus.r0_ready, g == 0);
        chk({tag, ".r1_ready"}, bus.r1_ready, g == 1);
        if (g == 0) ref_alu(op0, a0, b0, ed, ee);
        else        ref_alu(op1, a1, b1, ed, ee);
        tick();
        prio_m = 1 - g;
        // Requesters keep asking during EXEC/RESP; none may be granted.
        bus.r0_valid = 1'b1;
        bus.r1_valid = 1'b1;
        bus.r0_a = 8'($urandom);
        bus.r1_b = 8'($urandom);
        #1;
        chk({tag, ".exec_busy"}, bus.busy, 1);
        chk({tag, ".exec_vld"}, bus.resp_valid, 0);
        chk({tag, ".exec_rdy"}, {bus.r0_ready, bus.r1_ready}, 0);
        tick();
        for (int i = 0; i <= stall; i++) begin
            if (i == stall) bus.resp_ready = 1'b1;
            #1;
            chk({tag, ".resp_vld"}, bus.resp_valid, 1);
            chk({tag, ".resp_busy"}, bus.busy, 1);
            chk({tag, ".resp_id"}, bus.resp_id, g);
            chk({tag, ".resp_err"}, bus.resp_err, ee);
            if (ed >= 0) chk({tag, ".resp_data"}, bus.resp_data, ed);
            chk({tag, ".resp_rdy"}, {bus.r0_ready, bus.r1_ready}, 0);
            tick();
        end
        bus.resp_ready = 1'b0;
        bus.r0_valid = 1'b0;
        bus.r1_valid = 1'b0;
        #1;
        chk({tag, ".idle_vld"}, bus.resp_valid, 0);
        chk({tag, ".idle_busy"}, bus.busy, 0);
    endtask

    initial begin
        rst = 1'b1;
        bus.r0_valid = 1'b1; bus.r0_op = 4'h0; bus.r0_a = 8'h00; bus.r0_b = 8'h00;
        bus.r1_valid = 1'b1; bus.r1_op = 4'h0; bus.r1_a = 8'h00; bus.r1_b = 8'h00;
        bus.resp_ready = 1'b0;
        tick();
        tick();
        chk("rst.rdy", {bus.r0_ready, bus.r1_ready}, 0);
        chk("rst.vld", bus.resp_valid, 0);
        chk("rst.busy", bus.busy, 0);
        chk("rst.data", {bus.resp_data, bus.resp_id, bus.resp_err}, 0);
        bus.r0_valid = 1'b0;
        bus.r1_valid = 1'b0;
        rst = 1'b0;
        prio_m = 0;
        tick();

        run_txn(1, 0, 4'h0, 8'hF0, 8'h20, 4'h0, 8'h00, 8'h00, 0, "add_wrap");
        run_txn(0, 1, 4'h0, 8'h00, 8'h00, 4'h2, 8'h13, 8'h11, 5, "mul_stall");
        run_txn(1, 0, 4'hD, 8'h05, 8'h03, 4'h0, 8'h00, 8'h00, 0, "undef_op");
        run_txn(0, 1, 4'h0, 8'h00, 8'h00, 4'h8, 8'h01, 8'h09, 0, "shl_big");
        run_txn(1, 0, 4'hC, 8'h17, 8'h05, 4'h0, 8'h00, 8'h00, 0, "mod");
        run_txn(0, 1, 4'h0, 8'h00, 8'h00, 4'h1, 8'h02, 8'h05, 1, "sub_wrap");
`ifdef ALU_ARB_DIVZERO_CHK_EN
        run_txn(1, 0, 4'h3, 8'h07, 8'h00, 4'h0, 8'h00, 8'h00, 0, "div_zero");
`endif

        // Both requesters contending: grants must alternate.
        for (int i = 0; i < 6; i++)
            run_txn(1, 1, 4'h4, 8'($urandom), 8'($urandom), 4'h7, 8'($urandom), 8'($urandom),
                    0, "rr");

        // Reset while in EXEC discards the operation and restores the priority pointer.
        run_txn(1, 0, 4'h6, 8'h0F, 8'hF0, 4'h0, 8'h00, 8'h00, 0, "pre_rst");
        bus.r0_valid = 1'b1; bus.r0_op = 4'h0; bus.r0_a = 8'h11; bus.r0_b = 8'h22;
        #1;
        chk("rstx.accept", bus.r0_ready, 1);
        tick();
        rst = 1'b1;
        bus.r1_valid = 1'b1;
        #1;
        chk("rstx.rdy_in_rst", {bus.r0_ready, bus.r1_ready}, 0);
        tick();
        rst = 1'b0;
        prio_m = 0;
        bus.r0_valid = 1'b0;
        bus.r1_valid = 1'b0;
        #1;
        chk("rstx.busy", bus.busy, 0);
        for (int i = 0; i < 3; i++) begin
            chk("rstx.no_resp", bus.resp_valid, 0);
            tick();
        end
        run_txn(1, 1, 4'h0, 8'h01, 8'h01, 4'h0, 8'h02, 8'h02, 0, "post_rst");

        for (int i = 0; i < 30; i++) begin
            int vp;
            logic [7:0] b0;
            logic [7:0] b1;
            vp = int'($urandom_range(1, 3));
            b0 = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 10)) : 8'($urandom);
            b1 = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 10)) : 8'($urandom);
            run_txn(vp[0], vp[1], 4'($urandom), 8'($urandom), b0,
                    4'($urandom), 8'($urandom), b1, int'($urandom_range(0, 3)), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
